// File: rtl/sumador_serie_param_if.sv
// Start/done handshake and operand/result bus of the slice-serial adder/subtractor.
interface sumador_serie_param_if #(
    parameter int ANCHO = 16
);
    logic             Inicio;
    logic [ANCHO-1:0] X;
    logic [ANCHO-1:0] Y;
    logic             Resta;
    logic             CarriEntrada;
    logic             Ocupado;
    logic             Listo;
    logic [ANCHO-1:0] Salida;
    logic             CarriSalida;
    logic             Desborde;

    modport master (
        output Inicio, X, Y, Resta, CarriEntrada,
        input  Ocupado, Listo, Salida, CarriSalida, Desborde
    );

    modport slave (
        input  Inicio, X, Y, Resta, CarriEntrada,
        output Ocupado, Listo, Salida, CarriSalida, Desborde
    );
endinterface

// File: rtl/sumador_serie_param.sv
// Multi-cycle adder/subtractor: adds ANCHO_BLOQUE bits per clock, LSB slice first,
// with the inter-slice carry registered. Reports unsigned carry-out and signed overflow.
//
// state   | meaning
// REPOSO  | idle, waiting for Inicio; operands and carry captured on acceptance
// CALCULO | one slice added per edge, N edges in total
// FIN     | single cycle with Listo=1, result outputs valid
module sumador_serie_param #(
    parameter int ANCHO        = 16,
    parameter int ANCHO_BLOQUE = 4
) (
    input  logic                 Reloj,
    input  logic                 Reset,
    sumador_serie_param_if.slave bus
);
    localparam int N  = ANCHO / ANCHO_BLOQUE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        CALCULO = 2'd1,
        FIN     = 2'd2
    } estado_t;

    estado_t                 estado;
    estado_t                 estado_sig;
    logic [CW-1:0]           cuenta;
    logic [ANCHO-1:0]        op_a;
    logic [ANCHO-1:0]        op_b;
    logic                    acarreo;
    logic [ANCHO-1:0]        parcial;
    logic [ANCHO-1:0]        salida_q;
    logic                    carri_q;
    logic                    desborde_q;

    logic [ANCHO_BLOQUE-1:0] trozo_a;
    logic [ANCHO_BLOQUE-1:0] trozo_b;
    logic [ANCHO_BLOQUE:0]   suma_trozo;
    logic [ANCHO-1:0]        parcial_sig;
    logic                    carry_msb;
    logic                    ultimo;

    always_comb begin
        trozo_a     = op_a[ANCHO_BLOQUE-1:0];
        trozo_b     = op_b[ANCHO_BLOQUE-1:0];
        suma_trozo  = {1'b0, trozo_a} + {1'b0, trozo_b} + {{ANCHO_BLOQUE{1'b0}}, acarreo};
        parcial_sig = parcial >> ANCHO_BLOQUE;
        parcial_sig[ANCHO-1 -: ANCHO_BLOQUE] = suma_trozo[ANCHO_BLOQUE-1:0];
        // Carry into the top bit of the slice recovered from its sum bit and operand bits.
        carry_msb   = suma_trozo[ANCHO_BLOQUE-1] ^ trozo_a[ANCHO_BLOQUE-1] ^ trozo_b[ANCHO_BLOQUE-1];
        ultimo      = (cuenta == ULTIMO);
    end

    always_ff @(posedge Reloj or posedge Reset) begin
        if (Reset) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO:  if (bus.Inicio) estado_sig = CALCULO;
            CALCULO: if (ultimo) estado_sig = FIN;
            FIN:     estado_sig = REPOSO;
            default: estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge Reloj or posedge Reset) begin
        if (Reset) begin
            cuenta     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            acarreo    <= 1'b0;
            parcial    <= '0;
            salida_q   <= '0;
            carri_q    <= 1'b0;
            desborde_q <= 1'b0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (bus.Inicio) begin
                        op_a    <= bus.X;
                        op_b    <= bus.Resta ? ~bus.Y : bus.Y;
                        acarreo <= bus.Resta ? 1'b1 : bus.CarriEntrada;
                        cuenta  <= '0;
                    end
                end
                CALCULO: begin
                    op_a    <= op_a >> ANCHO_BLOQUE;
                    op_b    <= op_b >> ANCHO_BLOQUE;
                    acarreo <= suma_trozo[ANCHO_BLOQUE];
                    parcial <= parcial_sig;
                    if (ultimo) begin
                        cuenta     <= '0;
                        salida_q   <= parcial_sig;
                        carri_q    <= suma_trozo[ANCHO_BLOQUE];
                        desborde_q <= carry_msb ^ suma_trozo[ANCHO_BLOQUE];
                    end else begin
                        cuenta <= cuenta + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Ocupado     = (estado != REPOSO);
    assign bus.Listo       = (estado == FIN);
    assign bus.Salida      = salida_q;
    assign bus.CarriSalida = carri_q;
    assign bus.Desborde    = desborde_q;
endmodule

// File: tb/tb_sumador_serie_param.sv
// Randomised and directed checks of sumador_serie_param against an integer-arithmetic model.
module tb_sumador_serie_param;
    localparam int NP = 4;

    logic Reloj;
    logic Reset;
    int   n_vec;
    int   n_err;

    sumador_serie_param_if #(.ANCHO(16)) bus ();
    sumador_serie_param_if #(.ANCHO(4))  bus2 ();

    sumador_serie_param #(.ANCHO(16), .ANCHO_BLOQUE(4)) dut (
        .Reloj (Reloj),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    sumador_serie_param #(.ANCHO(4), .ANCHO_BLOQUE(1)) dut2 (
        .Reloj (Reloj),
        .Reset (Reset),
        .bus   (bus2.slave)
    );

    always #5 Reloj = ~Reloj;

    // Unsigned result/carry and signed overflow from plain integer arithmetic.
    function automatic void modelo(input int w, input int x, input int y, input bit resta,
                                   input bit cin, output int s, output bit c, output bit v);
        int m;
        int h;
        int sx;
        int sy;
        int ideal;
        m = 1 << w;
        h = 1 << (w - 1);
        if (!resta) begin
            s = (x + y + int'(cin)) % m;
            c = (x + y + int'(cin)) >= m;
        end else begin
            s = (x - y + m) % m;
            c = (x >= y);
        end
        sx    = (x >= h) ? x - m : x;
        sy    = (y >= h) ? y - m : y;
        ideal = resta ? sx - sy : sx + sy + int'(cin);
        v     = (ideal >= h) || (ideal < -h);
    endfunction

    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input bit resta,
                          input bit cin, input string nombre);
        int s;
        bit c;
        bit v;
        modelo(16, int'(x), int'(y), resta, cin, s, c, v);
        bus.X = x; bus.Y = y; bus.Resta = resta; bus.CarriEntrada = cin; bus.Inicio = 1'b1;
        @(posedge Reloj); #1;
        bus.Inicio = 1'b0; bus.X = 16'($urandom); bus.Y = 16'($urandom);
        bus.Resta = 1'($urandom); bus.CarriEntrada = 1'($urandom);
        n_vec++;
        if (bus.Ocupado !== 1'b1) begin
            n_err++;
            $display("FAIL %s ocupado: got %b want 1", nombre, bus.Ocupado);
        end
        for (int k = 1; k <= NP; k++) begin
            @(posedge Reloj); #1;
            if (k < NP) begin
                n_vec++;
                if (bus.Listo !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s early_listo: cycle %0d got %b want 0", nombre, k, bus.Listo);
                end
            end
        end
        n_vec++;
        if ({bus.Listo, bus.CarriSalida, bus.Desborde, bus.Salida} !== {1'b1, c, v, s[15:0]}) begin
            n_err++;
            $display("FAIL %s result: got L=%b C=%b V=%b S=%h want L=1 C=%b V=%b S=%h", nombre,
                     bus.Listo, bus.CarriSalida, bus.Desborde, bus.Salida, c, v, s[15:0]);
        end
        @(posedge Reloj); #1;
        n_vec++;
        if ({bus.Listo, bus.Ocupado} !== 2'b00) begin
            n_err++;
            $display("FAIL %s after_fin: got L=%b O=%b want 0 0", nombre, bus.Listo, bus.Ocupado);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.Inicio = 1'b1; bus.X = 16'hABCD; bus.Y = 16'h1234; bus.Resta = 1'b0; bus.CarriEntrada = 1'b1;
        bus2.Inicio = 1'b1; bus2.X = 4'h5; bus2.Y = 4'h6; bus2.Resta = 1'b0; bus2.CarriEntrada = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge Reloj); #1;
            n_vec++;
            if ({bus.Ocupado, bus.Listo, bus.CarriSalida, bus.Desborde, bus.Salida} !== 20'h0) begin
                n_err++;
                $display("FAIL reset_main: got O=%b L=%b C=%b V=%b S=%h want all 0", bus.Ocupado,
                         bus.Listo, bus.CarriSalida, bus.Desborde, bus.Salida);
            end
            n_vec++;
            if ({bus2.Ocupado, bus2.Listo, bus2.CarriSalida, bus2.Desborde, bus2.Salida} !== 8'h0) begin
                n_err++;
                $display("FAIL reset_small: got O=%b L=%b C=%b V=%b S=%h want all 0", bus2.Ocupado,
                         bus2.Listo, bus2.CarriSalida, bus2.Desborde, bus2.Salida);
            end
        end
        bus.Inicio = 1'b0; bus2.Inicio = 1'b0;
        Reset = 1'b0;
        @(posedge Reloj); #1;
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, "add_basic");
        n_vec++;
        if (bus.Salida !== 16'h5555) begin
            n_err++;
            $display("FAIL add_basic_const: got %h want 5555", bus.Salida);
        end
        run_op(16'h1234, 16'h4321, 1'b0, 1'b1, "add_cin");
        n_vec++;
        if (bus.Salida !== 16'h5556) begin
            n_err++;
            $display("FAIL add_cin_const: got %h want 5556", bus.Salida);
        end
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "carry_chain");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "signed_ovf");
        run_op(16'h0003, 16'h0005, 1'b1, 1'b0, "sub_borrow");
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, "sub_ovf");
        run_op(16'h0003, 16'h0005, 1'b1, 1'b1, "sub_cin_ignored");
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, "sub_ovf_cin_ignored");
        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, "sub_zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b, c2, d2;
        bit r1, r2, ci1, ci2;
        int s0, s1, s2;
        bit c0, c1, cc2, v0, v1, v2;
        bit exp_o, exp_l, exp_c, exp_v;
        logic [15:0] exp_s;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, "b2b_prior");
        modelo(16, 32'h1234, 32'h4321, 1'b0, 1'b0, s0, c0, v0);
        a = 16'($urandom); b = 16'($urandom); r1 = 1'($urandom); ci1 = 1'($urandom);
        c2 = 16'($urandom); d2 = 16'($urandom); r2 = 1'($urandom); ci2 = 1'($urandom);
        modelo(16, int'(a), int'(b), r1, ci1, s1, c1, v1);
        modelo(16, int'(c2), int'(d2), r2, ci2, s2, cc2, v2);
        bus.X = a; bus.Y = b; bus.Resta = r1; bus.CarriEntrada = ci1; bus.Inicio = 1'b1;
        @(posedge Reloj); #1;
        for (int k = 1; k <= 11; k++) begin
            if (k == 6) begin
                bus.X = c2; bus.Y = d2; bus.Resta = r2; bus.CarriEntrada = ci2;
            end else begin
                bus.X = 16'($urandom); bus.Y = 16'($urandom);
                bus.Resta = 1'($urandom); bus.CarriEntrada = 1'($urandom);
            end
            if (k == 11) bus.Inicio = 1'b0;
            @(posedge Reloj); #1;
            exp_o = !(k == 5 || k == 11);
            exp_l = (k == 4 || k == 10);
            if (k < 4) begin
                exp_s = s0[15:0]; exp_c = c0; exp_v = v0;
            end else if (k < 10) begin
                exp_s = s1[15:0]; exp_c = c1; exp_v = v1;
            end else begin
                exp_s = s2[15:0]; exp_c = cc2; exp_v = v2;
            end
            n_vec++;
            if ({bus.Ocupado, bus.Listo, bus.CarriSalida, bus.Desborde, bus.Salida} !==
                {exp_o, exp_l, exp_c, exp_v, exp_s}) begin
                n_err++;
                $display("FAIL back_to_back t+%0d: got O=%b L=%b C=%b V=%b S=%h want O=%b L=%b C=%b V=%b S=%h",
                         k, bus.Ocupado, bus.Listo, bus.CarriSalida, bus.Desborde, bus.Salida,
                         exp_o, exp_l, exp_c, exp_v, exp_s);
            end
        end
    endtask

    task automatic test_reset_abort();
        bus.X = 16'hFFFF; bus.Y = 16'h0001; bus.Resta = 1'b0; bus.CarriEntrada = 1'b0; bus.Inicio = 1'b1;
        @(posedge Reloj); #1;
        bus.Inicio = 1'b0;
        @(posedge Reloj);
        @(posedge Reloj);
        #3 Reset = 1'b1;
        #1;
        n_vec++;
        if ({bus.Ocupado, bus.Listo, bus.CarriSalida, bus.Desborde, bus.Salida} !== 20'h0) begin
            n_err++;
            $display("FAIL abort_clear: got O=%b L=%b C=%b V=%b S=%h want all 0", bus.Ocupado,
                     bus.Listo, bus.CarriSalida, bus.Desborde, bus.Salida);
        end
        @(posedge Reloj); #1;
        Reset = 1'b0;
        for (int k = 1; k <= NP + 2; k++) begin
            @(posedge Reloj); #1;
            n_vec++;
            if ({bus.Ocupado, bus.Listo, bus.Salida} !== 18'h0) begin
                n_err++;
                $display("FAIL abort_no_listo cycle %0d: got O=%b L=%b S=%h want 0 0 0000", k,
                         bus.Ocupado, bus.Listo, bus.Salida);
            end
        end
        run_op(16'h8000, 16'h8000, 1'b0, 1'b1, "after_abort");
    endtask

    task automatic run_small(input int x, input int y, input bit resta, input bit cin);
        int s;
        bit c;
        bit v;
        int lat;
        modelo(4, x, y, resta, cin, s, c, v);
        bus2.X = 4'(x); bus2.Y = 4'(y); bus2.Resta = resta; bus2.CarriEntrada = cin; bus2.Inicio = 1'b1;
        @(posedge Reloj); #1;
        bus2.Inicio = 1'b0; bus2.X = 4'($urandom); bus2.Y = 4'($urandom);
        lat = 0;
        do begin
            @(posedge Reloj); #1;
            lat++;
        end while (bus2.Listo !== 1'b1 && lat < 10);
        n_vec++;
        if (lat != NP || {bus2.CarriSalida, bus2.Salida, bus2.Desborde} !== {c, s[3:0], v}) begin
            n_err++;
            $display("FAIL sweep x=%0d y=%0d resta=%b: got lat=%0d C=%b S=%h V=%b want lat=%0d C=%b S=%h V=%b",
                     x, y, resta, lat, bus2.CarriSalida, bus2.Salida, bus2.Desborde, NP, c, s[3:0], v);
        end
        @(posedge Reloj); #1;
    endtask

    task automatic test_sweep();
        for (int r = 0; r < 2; r++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    run_small(x, y, r[0], (r == 1) ? 1'($urandom) : 1'b0);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        Reloj = 1'b0;
        Reset = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
